// File: rtl/rv_pkg.sv
// Shared RV32 decode constants: load funct3 encodings, instruction field
// positions and the all-zero pipeline bubble.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int RD_MSB = 11;
  localparam int RD_LSB = 7;
  localparam int F3_MSB = 14;
  localparam int F3_LSB = 12;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-write-back bus: registered pipeline fields in, decode read ports
// and commit status out.
interface wb_regfile_if #(
  parameter int CNT_W = 64
);
  logic [31:0]      alu_result_in;
  logic [31:0]      mem_data_in;
  logic             RegWrite_in;
  logic             MemToReg_in;
  logic             Jump_in;
  logic [31:0]      instr_in;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] instret;

  modport slave (
    input  alu_result_in, mem_data_in, RegWrite_in, MemToReg_in, Jump_in,
           instr_in, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
  );

  modport master (
    output alu_result_in, mem_data_in, RegWrite_in, MemToReg_in, Jump_in,
           instr_in, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
  );

endinterface

// File: rtl/wb_regfile_load_fmt.sv
// Load-data formatter: picks the byte/half lane of an aligned memory word
// and sign- or zero-extends it according to funct3.
module load_fmt
  import rv_pkg::*;
(
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] fmt_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = mem_data_i[7:0];
      2'd1:    byte_sel = mem_data_i[15:8];
      2'd2:    byte_sel = mem_data_i[23:16];
      default: byte_sel = mem_data_i[31:24];
    endcase
  end

  // Halfword lane depends only on off[1]; misaligned halves are not split.
  assign half_sel = off_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   fmt_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  fmt_o = {24'h0, byte_sel};
      F3_LH:   fmt_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  fmt_o = {16'h0, half_sel};
      F3_LW:   fmt_o = mem_data_i;
      default: fmt_o = mem_data_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the commit value, writes the 32x32 register file,
// serves two bypassed read ports and counts retired (non-bubble) instructions.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int BYPASS     = 1,
  parameter int RESET_REGS = 1,
  parameter int CNT_W      = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [31:0]      load_val;
  logic [31:0]      wb_data;
  logic             wb_en;
  logic [31:0]      regs_q [0:31];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  assign rd     = bus.instr_in[RD_MSB:RD_LSB];
  assign funct3 = bus.instr_in[F3_MSB:F3_LSB];

  load_fmt u_load_fmt (
    .mem_data_i (bus.mem_data_in),
    .off_i      (bus.alu_result_in[1:0]),
    .funct3_i   (funct3),
    .fmt_o      (load_val)
  );

  // Jump carries PC+4 in the ALU field and must win over a stale MemToReg.
  always_comb begin
    wb_data = bus.alu_result_in;
    if (!bus.Jump_in && bus.MemToReg_in) begin
      wb_data = load_val;
    end
  end

  assign wb_en       = bus.RegWrite_in && (rd != 5'd0);
  assign bus.wb_en   = wb_en;
  assign bus.wb_rd   = rd;
  assign bus.wb_data = wb_data;

  generate
    if (RESET_REGS != 0) begin : g_regs_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'h0;
          end
        end else if (wb_en) begin
          regs_q[rd] <= wb_data;
        end
      end
    end else begin : g_regs_ram
      // No reset on the array so it maps onto distributed/block RAM.
      always_ff @(posedge clk) begin
        if (rst_n && wb_en) begin
          regs_q[rd] <= wb_data;
        end
      end
    end
  endgenerate

  logic [4:0]  rd_addr [0:1];
  logic [31:0] rd_data [0:1];

  assign rd_addr[0]   = bus.rs1_addr;
  assign rd_addr[1]   = bus.rs2_addr;
  assign bus.rs1_data = rd_data[0];
  assign bus.rs2_data = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == 5'd0) ? 32'h0 :
                           ((BYPASS != 0) && wb_en && (rd_addr[gi] == rd)) ? wb_data :
                           regs_q[rd_addr[gi]];
    end
  endgenerate

  always_comb begin
    instret_d = instret_q;
    if (bus.instr_in != BUBBLE) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret = instret_q;

endmodule
